// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with a one-word holding register so that
// consecutive words serialise back to back on the product path.
module piso_stream #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t            state, next_state;
    logic [WIDTH-1:0]  sr, hr, sr_shifted;
    logic [CNT_W-1:0]  cnt;
    logic              hr_full, hr_full_nxt;
    logic              accept, last_shift, out_bit;

    assign load_ready = !hr_full && !flush;
    assign accept     = load_valid && load_ready;
    assign last_shift = (state == SHIFT) && shift_en && (cnt == CNT_W'(WIDTH - 1));
    assign out_bit    = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    assign sr_shifted = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state  = state;
        hr_full_nxt = hr_full;
        if (flush) begin
            next_state  = IDLE;
            hr_full_nxt = 1'b0;
        end else begin
            case (state)
                IDLE:  if (accept) next_state = SHIFT;
                SHIFT: begin
                    if (last_shift && !hr_full && !accept) next_state = IDLE;
                    if (last_shift && hr_full)             hr_full_nxt = 1'b0;
                    else if (accept && !last_shift)        hr_full_nxt = 1'b1;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr           <= '0;
            hr           <= '0;
            cnt          <= '0;
            hr_full      <= 1'b0;
            busy         <= 1'b0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            hr_full <= hr_full_nxt;
            busy    <= (next_state == SHIFT) || hr_full_nxt;
            if (flush) begin
                sr           <= '0;
                hr           <= '0;
                cnt          <= '0;
                serial_out   <= 1'b0;
                serial_valid <= 1'b0;
                done         <= 1'b0;
            end else begin
                serial_valid <= 1'b0;
                done         <= 1'b0;
                if (state == SHIFT && shift_en) begin
                    serial_out   <= out_bit;
                    serial_valid <= 1'b1;
                    done         <= last_shift;
                    if (!last_shift) begin
                        sr  <= sr_shifted;
                        cnt <= cnt + CNT_W'(1);
                    end else if (hr_full) begin
                        sr  <= hr;
                        cnt <= '0;
                    end else if (accept) begin
                        // Holding register empty: the new word skips it entirely.
                        sr  <= data_in;
                        cnt <= '0;
                    end else begin
                        sr  <= '0;
                        cnt <= '0;
                    end
                end
                if (state == IDLE && accept) begin
                    sr  <= data_in;
                    cnt <= '0;
                end
                if (state == SHIFT && accept && !last_shift) hr <= data_in;
            end
        end
    end

endmodule
